axi_sysid_reader: RTL and testbench

AXI4-Lite initiator that reads back a sysid peripheral located at BASE_ADDR.

---
 rtl/axi_sysid_reader_pkg.sv | 27 ++
 rtl/axi_sysid_reader_txn.sv | 115 +++++++++++
 rtl/axi_sysid_reader.sv | 177 +++++++++++++++++
 tb/tb_axi_sysid_reader.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_sysid_reader_pkg.sv
// Shared definitions for the sysid read-back engine: FSM encodings, register map, error codes.
package axi_sysid_reader_pkg;

    localparam logic [31:0] CORE_MAGIC = 32'h5359_4944;

    localparam logic [15:0] OFF_MAGIC = 16'h000C;
    localparam logic [15:0] OFF_DATA  = 16'h0084;
    localparam logic [15:0] OFF_PTR   = 16'h0088;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_MAGIC   = 2'd1,
        ERR_RESP    = 2'd2,
        ERR_TIMEOUT = 2'd3
    } err_e;

    typedef enum logic [2:0] {
        S_IDLE, S_RD_MAGIC, S_WR_PTR, S_RD_DATA, S_PUSH, S_DONE, S_ERR
    } state_e;

    typedef enum logic [2:0] {
        T_IDLE, T_AR, T_R, T_AW, T_B
    } txn_state_e;

endpackage

// File: rtl/axi_sysid_reader_txn.sv
// Single-outstanding AXI4-Lite read/write engine; reports completion, response status and
// a per-handshake-step timeout. Named axi_lite_master_txn; instantiated once by axi_sysid_reader.
module axi_lite_master_txn
    import axi_sysid_reader_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        req_write,
    input  logic [15:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        idle,
    output logic        ack,
    output logic        ack_ok,
    output logic [31:0] ack_rdata,
    output logic        tmo,
    output logic        m_axi_awvalid,
    output logic [15:0] m_axi_awaddr,
    input  logic        m_axi_awready,
    output logic        m_axi_wvalid,
    output logic [31:0] m_axi_wdata,
    input  logic        m_axi_wready,
    input  logic        m_axi_bvalid,
    input  logic [1:0]  m_axi_bresp,
    output logic        m_axi_bready,
    output logic        m_axi_arvalid,
    output logic [15:0] m_axi_araddr,
    input  logic        m_axi_arready,
    input  logic        m_axi_rvalid,
    input  logic [1:0]  m_axi_rresp,
    input  logic [31:0] m_axi_rdata,
    output logic        m_axi_rready
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);

    txn_state_e    st, nxt;
    logic [CW-1:0] cnt;
    logic          hs, waiting;
    logic          awv_q, wv_q;
    logic [15:0]   addr_q;
    logic [31:0]   wdata_q;

    // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        nxt     = st;
        hs      = 1'b0;
        waiting = 1'b1;
        case (st)
            T_IDLE: begin
                waiting = 1'b0;
                if (req) nxt = req_write ? T_AW : T_AR;
            end
            T_AR: if (m_axi_arready) begin hs = 1'b1; nxt = T_R; end
            T_R:  if (m_axi_rvalid)  begin hs = 1'b1; nxt = T_IDLE; end
            T_AW: begin
                hs = (awv_q && m_axi_awready) || (wv_q && m_axi_wready);
                if ((!awv_q || m_axi_awready) && (!wv_q || m_axi_wready)) nxt = T_B;
            end
            T_B:  if (m_axi_bvalid)  begin hs = 1'b1; nxt = T_IDLE; end
            default: begin
                waiting = 1'b0;
                nxt     = T_IDLE;
            end
        endcase
        // A wait that reaches its limit abandons the transaction outright.
        tmo = waiting && !hs && (cnt == LIMIT);
        if (tmo) nxt = T_IDLE;
    end

    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st      <= T_IDLE;
            cnt     <= '0;
            awv_q   <= 1'b0;
            wv_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            st  <= nxt;
            cnt <= (waiting && !hs && !tmo) ? cnt + CW'(1) : '0;
            if (st == T_IDLE && req) begin
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                awv_q   <= req_write;
                wv_q    <= req_write;
            end else if (st == T_AW && !tmo) begin
                if (m_axi_awready) awv_q <= 1'b0;
                if (m_axi_wready)  wv_q  <= 1'b0;
            end else begin
                awv_q <= 1'b0;
                wv_q  <= 1'b0;
            end
        end
    end

    assign idle      = (st == T_IDLE);
    assign ack       = (st == T_R && m_axi_rvalid) || (st == T_B && m_axi_bvalid);
    assign ack_ok    = (st == T_R) ? (m_axi_rresp == RESP_OKAY) : (m_axi_bresp == RESP_OKAY);
    assign ack_rdata = m_axi_rdata;

    assign m_axi_arvalid = (st == T_AR);
    assign m_axi_rready  = (st == T_R);
    assign m_axi_bready  = (st == T_B);
    assign m_axi_awvalid = awv_q;
    assign m_axi_wvalid  = wv_q;
    assign m_axi_araddr  = addr_q;
    assign m_axi_awaddr  = addr_q;
    assign m_axi_wdata   = wdata_q;

endmodule

// File: rtl/axi_sysid_reader.sv
// Sysid self-check engine: verifies the magic word, sets the ROM pointer and streams ROM words.
// Optional running checksum enabled by defining SYSID_READER_CHECKSUM_EN.
module axi_sysid_reader
    import axi_sysid_reader_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR      = 16'h0000,
    parameter int          START_WORD     = 0,
    parameter int          NUM_WORDS      = 64,
    parameter int          TIMEOUT_CYCLES = 1024
) (
    input  logic        m_axi_aclk,
    input  logic        m_axi_areset,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic [1:0]  err,
    output logic [31:0] m_axis_data,
    output logic        m_axis_valid,
    input  logic        m_axis_ready,
    output logic        m_axis_last,
    output logic [31:0] checksum,
    output logic        m_axi_awvalid,
    output logic [15:0] m_axi_awaddr,
    input  logic        m_axi_awready,
    output logic        m_axi_wvalid,
    output logic [31:0] m_axi_wdata,
    output logic [3:0]  m_axi_wstrb,
    input  logic        m_axi_wready,
    input  logic        m_axi_bvalid,
    input  logic [1:0]  m_axi_bresp,
    output logic        m_axi_bready,
    output logic        m_axi_arvalid,
    output logic [15:0] m_axi_araddr,
    input  logic        m_axi_arready,
    input  logic        m_axi_rvalid,
    input  logic [1:0]  m_axi_rresp,
    input  logic [31:0] m_axi_rdata,
    output logic        m_axi_rready,
    output logic [2:0]  m_axi_awprot,
    output logic [2:0]  m_axi_arprot
);

    localparam int BW = $clog2(NUM_WORDS + 1);
    localparam logic [BW-1:0] LAST_BEAT = BW'(NUM_WORDS - 1);

    state_e        state, nxt;
    err_e          err_q, fault;
    logic [BW-1:0] beat_cnt;
    logic [31:0]   data_q;
    logic          txn_req, txn_write, txn_idle, txn_ack, txn_ok, txn_tmo;
    logic [15:0]   txn_addr;
    logic [31:0]   txn_rdata;
    logic          start_ok, beat_ok;

    assign start_ok = (state == S_IDLE) && start;
    assign beat_ok  = (state == S_PUSH) && m_axis_ready;

    always_ff @(posedge m_axi_aclk or posedge m_axi_areset) begin
        if (m_axi_areset) state <= S_IDLE;
        else              state <= nxt;
    end

    always_comb begin
        nxt       = state;
        fault     = ERR_NONE;
        txn_req   = 1'b0;
        txn_write = 1'b0;
        txn_addr  = BASE_ADDR + OFF_MAGIC;
        case (state)
            S_IDLE: if (start) nxt = S_RD_MAGIC;
            S_RD_MAGIC, S_WR_PTR, S_RD_DATA: begin
                // Issue exactly once per state: the engine is idle only before the request.
                txn_req   = txn_idle;
                txn_write = (state == S_WR_PTR);
                if (state == S_WR_PTR)       txn_addr = BASE_ADDR + OFF_PTR;
                else if (state == S_RD_DATA) txn_addr = BASE_ADDR + OFF_DATA;
                if (txn_tmo) begin
                    nxt   = S_ERR;
                    fault = ERR_TIMEOUT;
                end else if (txn_ack && !txn_ok) begin
                    nxt   = S_ERR;
                    fault = ERR_RESP;
                end else if (txn_ack) begin
                    case (state)
                        S_RD_MAGIC: begin
                            if (txn_rdata != CORE_MAGIC) begin
                                nxt   = S_ERR;
                                fault = ERR_MAGIC;
                            end else begin
                                nxt = S_WR_PTR;
                            end
                        end
                        S_WR_PTR: nxt = S_RD_DATA;
                        default:  nxt = S_PUSH;
                    endcase
                end
            end
            // The next 0x84 read bumps the slave pointer, so it waits for beat acceptance.
            S_PUSH:  if (m_axis_ready) nxt = (beat_cnt == LAST_BEAT) ? S_DONE : S_RD_DATA;
            default: nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge m_axi_aclk or posedge m_axi_areset) begin
        if (m_axi_areset) begin
            err_q    <= ERR_NONE;
            beat_cnt <= '0;
            data_q   <= '0;
        end else begin
            if (start_ok) begin
                err_q    <= ERR_NONE;
                beat_cnt <= '0;
            end
            if (nxt == S_ERR) err_q <= fault;
            if (state == S_RD_DATA && txn_ack && txn_ok) data_q <= txn_rdata;
            if (beat_ok) beat_cnt <= beat_cnt + BW'(1);
        end
    end

`ifdef SYSID_READER_CHECKSUM_EN
    logic [31:0] sum_q;

    always_ff @(posedge m_axi_aclk or posedge m_axi_areset) begin
        if (m_axi_areset)  sum_q <= '0;
        else if (start_ok) sum_q <= '0;
        else if (beat_ok)  sum_q <= sum_q + data_q;
    end

    assign checksum = sum_q;
`else
    assign checksum = '0;
`endif

    axi_lite_master_txn #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_txn (
        .clk           (m_axi_aclk),
        .rst           (m_axi_areset),
        .req           (txn_req),
        .req_write     (txn_write),
        .req_addr      (txn_addr),
        .req_wdata     (32'(START_WORD)),
        .idle          (txn_idle),
        .ack           (txn_ack),
        .ack_ok        (txn_ok),
        .ack_rdata     (txn_rdata),
        .tmo           (txn_tmo),
        .m_axi_awvalid (m_axi_awvalid),
        .m_axi_awaddr  (m_axi_awaddr),
        .m_axi_awready (m_axi_awready),
        .m_axi_wvalid  (m_axi_wvalid),
        .m_axi_wdata   (m_axi_wdata),
        .m_axi_wready  (m_axi_wready),
        .m_axi_bvalid  (m_axi_bvalid),
        .m_axi_bresp   (m_axi_bresp),
        .m_axi_bready  (m_axi_bready),
        .m_axi_arvalid (m_axi_arvalid),
        .m_axi_araddr  (m_axi_araddr),
        .m_axi_arready (m_axi_arready),
        .m_axi_rvalid  (m_axi_rvalid),
        .m_axi_rresp   (m_axi_rresp),
        .m_axi_rdata   (m_axi_rdata),
        .m_axi_rready  (m_axi_rready)
    );

    assign busy         = (state == S_RD_MAGIC) || (state == S_WR_PTR) ||
                          (state == S_RD_DATA)  || (state == S_PUSH);
    assign done         = (state == S_DONE);
    assign err          = err_q;
    assign m_axis_data  = data_q;
    assign m_axis_valid = (state == S_PUSH);
    assign m_axis_last  = (state == S_PUSH) && (beat_cnt == LAST_BEAT);
    assign m_axi_wstrb  = 4'hF;
    assign m_axi_awprot = 3'b000;
    assign m_axi_arprot = 3'b000;

endmodule

// File: tb/tb_axi_sysid_reader.sv
// Bench for axi_sysid_reader: behavioural sysid slave with random latencies, stream sink and
// run-level model; the expected checksum follows SYSID_READER_CHECKSUM_EN.
module tb_axi_sysid_reader;
    import axi_sysid_reader_pkg::*;

    localparam logic [15:0] BASE       = 16'h0400;
    localparam int          START_WORD = 0;
    localparam int          NUM_WORDS  = 4;
    localparam int          TMO        = 32;

    logic        clk, rst, start;
    logic        busy, done, m_axis_valid, m_axis_ready, m_axis_last;
    logic [1:0]  err;
    logic [31:0] m_axis_data, checksum;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [15:0] awaddr, araddr;
    logic [31:0] wdata, rdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;
    logic [2:0]  awprot, arprot;

    axi_sysid_reader #(
        .BASE_ADDR(BASE), .START_WORD(START_WORD), .NUM_WORDS(NUM_WORDS), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .m_axi_aclk(clk), .m_axi_areset(rst), .start(start), .busy(busy), .done(done), .err(err),
        .m_axis_data(m_axis_data), .m_axis_valid(m_axis_valid), .m_axis_ready(m_axis_ready),
        .m_axis_last(m_axis_last), .checksum(checksum),
        .m_axi_awvalid(awvalid), .m_axi_awaddr(awaddr), .m_axi_awready(awready),
        .m_axi_wvalid(wvalid), .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wready(wready),
        .m_axi_bvalid(bvalid), .m_axi_bresp(bresp), .m_axi_bready(bready),
        .m_axi_arvalid(arvalid), .m_axi_araddr(araddr), .m_axi_arready(arready),
        .m_axi_rvalid(rvalid), .m_axi_rresp(rresp), .m_axi_rdata(rdata), .m_axi_rready(rready),
        .m_axi_awprot(awprot), .m_axi_arprot(arprot)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Slave configuration and ROM contents
    logic [31:0] rom [16];
    logic [31:0] magic_val;
    int          bad_r_at, stall_beat, stall_left;
    bit          bad_b, ar_stuck, rand_dly, sink_rand, stall_on, extra_start, start_on_done;

    // Slave state and logs
    int          ptr, ar_dly, r_dly, aw_dly, w_dly, b_dly, data_reads;
    bit          r_pend, aw_got, w_got;
    logic [15:0] r_addr, aw_a;
    logic [31:0] w_d;
    logic [3:0]  w_s;
    int          ar_cnt, aw_cnt;
    logic [15:0] ar_addrs[$];

    function automatic int rdly();
        return rand_dly ? int'($urandom_range(0, 3)) : 0;
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            arready = 0; rvalid = 0; rresp = 0; rdata = 0;
            awready = 0; wready = 0; bvalid = 0; bresp = 0;
            r_pend = 0; aw_got = 0; w_got = 0; ptr = 0;
            ar_dly = 0; r_dly = 0; aw_dly = 0; w_dly = 0; b_dly = 0;
        end else begin
            if (arready) begin
                arready = 0; r_pend = 1; r_dly = rdly();
            end else if (arvalid && !ar_stuck && !r_pend && !rvalid) begin
                if (ar_dly > 0) ar_dly--;
                else begin
                    arready = 1; r_addr = araddr; ar_cnt++;
                    ar_addrs.push_back(araddr); ar_dly = rdly();
                end
            end
            if (rvalid) begin
                rvalid = 0; rresp = 0;
            end else if (r_pend) begin
                if (r_dly > 0) r_dly--;
                else begin
                    r_pend = 0; rvalid = 1; rresp = 2'b00;
                    if (r_addr == BASE + 16'h000C) rdata = magic_val;
                    else if (r_addr == BASE + 16'h0084) begin
                        data_reads++;
                        if (data_reads == bad_r_at) begin
                            rresp = 2'b10; rdata = $urandom;
                        end else rdata = rom[ptr % 16];
                        ptr++;
                    end else begin
                        rresp = 2'b11; rdata = 32'h0;
                    end
                end
            end
            if (awready) begin
                awready = 0; aw_got = 1;
            end else if (awvalid && !aw_got) begin
                if (aw_dly > 0) aw_dly--;
                else begin awready = 1; aw_a = awaddr; aw_cnt++; aw_dly = rdly(); end
            end
            if (wready) begin
                wready = 0; w_got = 1;
            end else if (wvalid && !w_got) begin
                if (w_dly > 0) w_dly--;
                else begin wready = 1; w_d = wdata; w_s = wstrb; w_dly = rdly(); end
            end
            if (bvalid) begin
                bvalid = 0; bresp = 0;
            end else if (aw_got && w_got) begin
                if (b_dly > 0) b_dly--;
                else begin
                    aw_got = 0; w_got = 0; bvalid = 1;
                    bresp = bad_b ? 2'b10 : 2'b00;
                    if (!bad_b && aw_a == BASE + 16'h0088) ptr = int'(w_d);
                    b_dly = rdly();
                end
            end
        end
    end

    // Stream sink: every beat checked against the ROM, holds checked while stalled
    int          beat_idx, stall_ar;
    bit          pend;
    logic [31:0] pend_data;

    always @(negedge clk) begin
        if (rst) begin
            m_axis_ready = 0; pend = 0;
        end else begin
            if (pend) begin
                check("axis_hold_valid", m_axis_valid, 1);
                check("axis_hold_data", m_axis_data, pend_data);
            end
            if (m_axis_valid && beat_idx == stall_beat && stall_left > 0) begin
                if (!stall_on) begin stall_on = 1; stall_ar = ar_cnt; end
                m_axis_ready = 0;
                stall_left--;
                if (stall_left == 0) check("stall_no_ar", ar_cnt, stall_ar);
            end else begin
                m_axis_ready = sink_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            if (m_axis_valid && m_axis_ready) begin
                if (beat_idx < NUM_WORDS) begin
                    check("beat_data", m_axis_data, rom[START_WORD + beat_idx]);
                    check("beat_last", m_axis_last, beat_idx == NUM_WORDS - 1);
                end else begin
                    check("beat_overrun", beat_idx, NUM_WORDS - 1);
                end
                beat_idx++;
                pend = 0;
            end else begin
                pend = m_axis_valid; pend_data = m_axis_data;
            end
        end
    end

    // Cycle-accurate event monitor
    int          cyc = 0;
    int          arv_rise_cyc, err_cyc, done_cnt;
    logic [15:0] arv_rise_addr;
    logic        arv_prev = 0;
    logic [1:0]  err_prev = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (arvalid && !arv_prev) begin arv_rise_cyc = cyc; arv_rise_addr = araddr; end
        if (err != 0 && err_prev == 0) err_cyc = cyc;
        if (done) done_cnt++;
        arv_prev = arvalid;
        err_prev = err;
    end

    task automatic cfg(input logic [31:0] magic, input int bad_r, input bit bresp_bad,
                       input bit stuck, input bit rd, input bit sr, input int stall);
        magic_val = magic; bad_r_at = bad_r; bad_b = bresp_bad; ar_stuck = stuck;
        rand_dly = rd; sink_rand = sr; stall_beat = stall; stall_left = 20; stall_on = 0;
        extra_start = 0; start_on_done = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ctrl"}, 32'({busy, done, err, m_axis_valid, m_axis_last, arvalid, awvalid,
                                  wvalid, bready, rready}), 32'd0);
        check({tag, "_axis_data"}, m_axis_data, 32'd0);
        check({tag, "_checksum"}, checksum, 32'd0);
        check({tag, "_addr"}, {araddr, awaddr}, 32'd0);
        check({tag, "_wdata"}, wdata, 32'd0);
    endtask

    task automatic do_run(input string tag);
        int          exp_err, exp_beats, exp_ar, exp_aw;
        logic [31:0] exp_sum;
        bit          finished;
        // Run-level model derived from the slave configuration
        if (ar_stuck)                      begin exp_err = 3; exp_beats = 0; exp_ar = 0; exp_aw = 0; end
        else if (magic_val != CORE_MAGIC)  begin exp_err = 1; exp_beats = 0; exp_ar = 1; exp_aw = 0; end
        else if (bad_b)                    begin exp_err = 2; exp_beats = 0; exp_ar = 1; exp_aw = 1; end
        else if (bad_r_at > 0 && bad_r_at <= NUM_WORDS) begin
            exp_err = 2; exp_beats = bad_r_at - 1; exp_ar = 1 + bad_r_at; exp_aw = 1;
        end else begin exp_err = 0; exp_beats = NUM_WORDS; exp_ar = 1 + NUM_WORDS; exp_aw = 1; end
        exp_sum = 0;
`ifdef SYSID_READER_CHECKSUM_EN
        for (int i = 0; i < exp_beats; i++) exp_sum += rom[START_WORD + i];
`endif
        @(negedge clk);
        ar_cnt = 0; aw_cnt = 0; ar_addrs.delete(); beat_idx = 0; done_cnt = 0;
        data_reads = 0; arv_rise_cyc = -1; err_cyc = -1;
        start = 1;
        @(negedge clk);
        start = 0;
        check({tag, "_busy_after_start"}, busy, 1);
        check({tag, "_err_cleared"}, err, 0);
        if (extra_start) begin
            start = 1; @(negedge clk); start = 0;
        end
        finished = 0;
        for (int i = 0; i < 4000 && !finished; i++) begin
            if (done || err != 0) finished = 1;
            else @(negedge clk);
        end
        check({tag, "_finished"}, finished, 1);
        check({tag, "_busy_at_end"}, busy, 0);
        if (start_on_done) begin
            start = 1; @(negedge clk); start = 0;
            check({tag, "_start_on_done_ignored"}, busy, 0);
        end
        repeat (12) @(negedge clk);
        check({tag, "_err"}, err, exp_err);
        check({tag, "_beats"}, beat_idx, exp_beats);
        check({tag, "_done_pulses"}, done_cnt, exp_err == 0 ? 1 : 0);
        check({tag, "_ar_count"}, ar_cnt, exp_ar);
        check({tag, "_aw_count"}, aw_cnt, exp_aw);
        check({tag, "_checksum"}, checksum, exp_sum);
        foreach (ar_addrs[i])
            check({tag, "_ar_addr"}, ar_addrs[i], i == 0 ? BASE + 16'h000C : BASE + 16'h0084);
        if (exp_aw == 1) begin
            check({tag, "_aw_addr"}, aw_a, BASE + 16'h0088);
            check({tag, "_w_data"}, w_d, START_WORD);
            check({tag, "_w_strb"}, w_s, 4'hF);
        end
        if (ar_stuck) begin
            check({tag, "_ar_addr_stuck"}, arv_rise_addr, BASE + 16'h000C);
            check({tag, "_arvalid_to_err"}, err_cyc - arv_rise_cyc, TMO);
        end
    endtask

    initial begin
        rst = 1; start = 0; m_axis_ready = 0;
        for (int i = 0; i < 16; i++) rom[i] = 32'h100 + i;
        cfg(CORE_MAGIC, 0, 0, 0, 0, 0, -1);
        #12;
        check_reset_outputs("reset");
        check("prot", {awprot, arprot}, 0);
        @(negedge clk);
        rst = 0;

        cfg(CORE_MAGIC, 0, 0, 0, 0, 0, -1);
        start_on_done = 1;
        do_run("basic");
`ifdef SYSID_READER_CHECKSUM_EN
        check("basic_sum_value", checksum, 32'h406);
`endif

        cfg(32'hDEADBEEF, 0, 0, 0, 0, 0, -1);
        do_run("magic");

        cfg(CORE_MAGIC, 2, 0, 0, 0, 0, -1);
        do_run("rresp");

        cfg(CORE_MAGIC, 0, 0, 1, 0, 0, -1);
        do_run("timeout");

        cfg(CORE_MAGIC, 0, 0, 0, 0, 0, 1);
        do_run("stall");
        check("stall_happened", stall_on, 1);

        // Reset while the pointer write is outstanding
        cfg(CORE_MAGIC, 0, 0, 0, 0, 0, -1);
        @(negedge clk);
        start = 1;
        @(negedge clk);
        start = 0;
        for (int i = 0; i < 50 && !awvalid; i++) @(negedge clk);
        check("midrst_reached_wr", awvalid, 1);
        #2 rst = 1;
        #1 check_reset_outputs("midrst");
        @(negedge clk);
        @(negedge clk);
        rst = 0;
        do_run("after_reset");

        for (int n = 0; n < 8; n++) begin
            int sel;
            for (int i = 0; i < 16; i++) rom[i] = $urandom;
            sel = int'($urandom_range(0, 5));
            cfg(CORE_MAGIC, sel == 1 ? int'($urandom_range(1, NUM_WORDS)) : 0, sel == 0, 0, 1, 1, -1);
            extra_start = 1;
            do_run("random");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
